// File: rtl/fft_peak_tracker.sv
// Per-frame peak finder over the FFT bin stream, followed by a cross-frame
// debouncer that publishes a stable note bin.
module fft_peak_tracker #(
  parameter int MAG_W         = 64,
  parameter int IDX_W         = 11,
  parameter int MIN_BIN       = 2,
  parameter int MAX_BIN       = 1023,
  parameter int THRESH        = 4096,
  parameter int STABLE_FRAMES = 3,
  parameter int TOL           = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mag_valid,
  input  logic [MAG_W-1:0] mag,
  input  logic [IDX_W-1:0] index,
  input  logic             done,
  output logic             peak_valid,
  output logic             peak_found,
  output logic [IDX_W-1:0] peak_index,
  output logic [MAG_W-1:0] peak_mag,
  output logic             note_valid,
  output logic [IDX_W-1:0] note_index,
  output logic             note_update,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [IDX_W-1:0] MIN_IDX    = IDX_W'(MIN_BIN);
  localparam logic [IDX_W-1:0] MAX_IDX    = IDX_W'(MAX_BIN);
  localparam logic [IDX_W-1:0] TOL_IDX    = IDX_W'(TOL);
  localparam logic [MAG_W-1:0] THRESH_MAG = MAG_W'(THRESH);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Larger minus smaller, so the distance never wraps around bin 0.
  function automatic logic [IDX_W-1:0] bin_delta(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  state_t           state_r, state_n_s;
  logic [MAG_W-1:0] best_mag_r, best_mag_s;
  logic [IDX_W-1:0] best_idx_r, best_idx_s;
  logic             hit_r, hit_s, cand_s, take_s, frame_end_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s, silent_r, silent_n_s;
  logic [IDX_W-1:0] ref_r, ref_n_s, delta_s, note_index_n_s;
  logic             note_valid_n_s, note_change_s;
  logic             peak_valid_r, peak_found_r, note_valid_r, note_update_r, frame_err_r;
  logic [IDX_W-1:0] peak_index_r, note_index_r;
  logic [MAG_W-1:0] peak_mag_r;

  // Next-state logic; a start inside SCAN restarts the scan in place.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_n_s = ST_SCAN;
        else       state_n_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (start)     state_n_s = ST_SCAN;
        else if (done) state_n_s = ST_REPORT;
        else           state_n_s = ST_SCAN;
      end
      ST_REPORT: state_n_s = ST_UPDATE;
      ST_UPDATE: state_n_s = ST_IDLE;
      default:   state_n_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_n_s;
  end

  // Running max including the current bin; strict compare keeps the lower index on ties.
  always_comb begin
    cand_s      = mag_valid && (index >= MIN_IDX) && (index <= MAX_IDX) && (mag > THRESH_MAG);
    take_s      = cand_s && (!hit_r || (mag > best_mag_r));
    best_mag_s  = take_s ? mag   : best_mag_r;
    best_idx_s  = take_s ? index : best_idx_r;
    hit_s       = hit_r || cand_s;
    frame_end_s = (state_r == ST_SCAN) && done && !start;
  end

  // Scan accumulators: cleared on every start, updated only while scanning.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      best_mag_r <= '0;
      best_idx_r <= '0;
      hit_r      <= 1'b0;
    end else if (start && ((state_r == ST_IDLE) || (state_r == ST_SCAN))) begin
      best_mag_r <= '0;
      best_idx_r <= '0;
      hit_r      <= 1'b0;
    end else if (state_r == ST_SCAN) begin
      best_mag_r <= best_mag_s;
      best_idx_r <= best_idx_s;
      hit_r      <= hit_s;
    end else begin
      best_mag_r <= best_mag_r;
      best_idx_r <= best_idx_r;
      hit_r      <= hit_r;
    end
  end

  // Per-frame result registers and the abort pulse.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      peak_valid_r <= 1'b0;
      peak_found_r <= 1'b0;
      peak_index_r <= '0;
      peak_mag_r   <= '0;
      frame_err_r  <= 1'b0;
    end else begin
      peak_valid_r <= frame_end_s;
      frame_err_r  <= (state_r == ST_SCAN) && start;
      if (frame_end_s) begin
        peak_found_r <= hit_s;
        peak_index_r <= hit_s ? best_idx_s : '0;
        peak_mag_r   <= hit_s ? best_mag_s : '0;
      end else begin
        peak_found_r <= peak_found_r;
        peak_index_r <= peak_index_r;
        peak_mag_r   <= peak_mag_r;
      end
    end
  end

  // Debounce decision, evaluated from the freshly latched frame result.
  always_comb begin
    delta_s        = bin_delta(peak_index_r, ref_r);
    cnt_n_s        = cnt_r;
    silent_n_s     = silent_r;
    ref_n_s        = ref_r;
    note_valid_n_s = note_valid_r;
    note_index_n_s = note_index_r;
    if (peak_found_r) begin
      silent_n_s = '0;
      ref_n_s    = peak_index_r;
      if (delta_s <= TOL_IDX) begin
        if (cnt_r == STABLE_CNT) cnt_n_s = cnt_r;
        else                     cnt_n_s = cnt_r + 1'b1;
      end else begin
        cnt_n_s = CNT_W'(1);
      end
    end else begin
      cnt_n_s = '0;
      if (silent_r == STABLE_CNT) silent_n_s = silent_r;
      else                        silent_n_s = silent_r + 1'b1;
    end
    if (cnt_n_s == STABLE_CNT) begin
      note_valid_n_s = 1'b1;
      note_index_n_s = ref_n_s;
    end else if (silent_n_s == STABLE_CNT) begin
      note_valid_n_s = 1'b0;
    end else begin
      note_valid_n_s = note_valid_r;
    end
    note_change_s = (note_valid_n_s != note_valid_r) || (note_index_n_s != note_index_r);
  end

  // Debounce state and note outputs advance once per reported frame.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r         <= '0;
      silent_r      <= '0;
      ref_r         <= '0;
      note_valid_r  <= 1'b0;
      note_index_r  <= '0;
      note_update_r <= 1'b0;
    end else if (state_r == ST_REPORT) begin
      cnt_r         <= cnt_n_s;
      silent_r      <= silent_n_s;
      ref_r         <= ref_n_s;
      note_valid_r  <= note_valid_n_s;
      note_index_r  <= note_index_n_s;
      note_update_r <= note_change_s;
    end else begin
      cnt_r         <= cnt_r;
      silent_r      <= silent_r;
      ref_r         <= ref_r;
      note_valid_r  <= note_valid_r;
      note_index_r  <= note_index_r;
      note_update_r <= 1'b0;
    end
  end

  assign peak_valid  = peak_valid_r;
  assign peak_found  = peak_found_r;
  assign peak_index  = peak_index_r;
  assign peak_mag    = peak_mag_r;
  assign note_valid  = note_valid_r;
  assign note_index  = note_index_r;
  assign note_update = note_update_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed bench for fft_peak_tracker: per-frame peak reporting, debounce,
// frame abort and asynchronous reset behaviour.
module tb_fft_peak_tracker;

  logic        CLOCK_50;
  logic        reset_n;
  logic        start;
  logic        mag_valid;
  logic [63:0] mag;
  logic [10:0] index;
  logic        done;
  logic        peak_valid;
  logic        peak_found;
  logic [10:0] peak_index;
  logic [63:0] peak_mag;
  logic        note_valid;
  logic [10:0] note_index;
  logic        note_update;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  fft_peak_tracker dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .start       (start),
    .mag_valid   (mag_valid),
    .mag         (mag),
    .index       (index),
    .done        (done),
    .peak_valid  (peak_valid),
    .peak_found  (peak_found),
    .peak_index  (peak_index),
    .peak_mag    (peak_mag),
    .note_valid  (note_valid),
    .note_index  (note_index),
    .note_update (note_update),
    .frame_err   (frame_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bin(input logic [10:0] idx, input logic [63:0] m, input logic last);
    mag_valid = 1'b1;
    index     = idx;
    mag       = m;
    done      = last;
    tick();
    mag_valid = 1'b0;
    done      = 1'b0;
  endtask

  // Called right after the done bin: checks the REPORT cycle, then the UPDATE cycle.
  task automatic end_frame(input string tag, input logic efound, input logic [10:0] eidx,
                           input logic [63:0] emag, input logic env, input logic [10:0] eni,
                           input logic enu);
    chk({tag, "/peak_valid"}, 64'(peak_valid), 64'd1);
    chk({tag, "/peak_found"}, 64'(peak_found), 64'(efound));
    chk({tag, "/peak_index"}, 64'(peak_index), 64'(eidx));
    chk({tag, "/peak_mag"}, peak_mag, emag);
    tick();
    chk({tag, "/peak_valid_low"}, 64'(peak_valid), 64'd0);
    chk({tag, "/note_update"}, 64'(note_update), 64'(enu));
    chk({tag, "/note_valid"}, 64'(note_valid), 64'(env));
    chk({tag, "/note_index"}, 64'(note_index), 64'(eni));
    tick();
  endtask

  task automatic peak_frame(input string tag, input logic [10:0] idx, input logic [63:0] m,
                            input logic env, input logic [10:0] eni, input logic enu);
    send_start();
    send_bin(idx, m, 1'b1);
    end_frame(tag, 1'b1, idx, m, env, eni, enu);
  endtask

  task automatic quiet_frame(input string tag, input logic env, input logic [10:0] eni,
                             input logic enu);
    send_start();
    send_bin(11'd10, 64'd4096, 1'b0);
    send_bin(11'd20, 64'd4096, 1'b1);
    end_frame(tag, 1'b0, 11'd0, 64'd0, env, eni, enu);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/peak_valid"}, 64'(peak_valid), 64'd0);
    chk({tag, "/peak_found"}, 64'(peak_found), 64'd0);
    chk({tag, "/peak_index"}, 64'(peak_index), 64'd0);
    chk({tag, "/peak_mag"}, peak_mag, 64'd0);
    chk({tag, "/note_valid"}, 64'(note_valid), 64'd0);
    chk({tag, "/note_index"}, 64'(note_index), 64'd0);
    chk({tag, "/note_update"}, 64'(note_update), 64'd0);
    chk({tag, "/frame_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    mag_valid = 1'b0;
    mag       = 64'd0;
    index     = 11'd0;
    done      = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Full sweep of bins 0..1023 with one strong bin at 40.
    send_start();
    for (int b = 0; b < 1024; b++) begin
      send_bin(11'(b), (b == 40) ? 64'd9000 : 64'd100, (b == 1023) ? 1'b1 : 1'b0);
      if (b == 1022) chk("sweep/no_early_peak", 64'(peak_valid), 64'd0);
    end
    end_frame("sweep", 1'b1, 11'd40, 64'd9000, 1'b0, 11'd0, 1'b0);

    // Bin 1 excluded by MIN_BIN; equal magnitudes keep the lower index.
    send_start();
    send_bin(11'd1, 64'd1000000, 1'b0);
    send_bin(11'd50, 64'd5000, 1'b0);
    send_bin(11'd60, 64'd5000, 1'b1);
    end_frame("tie", 1'b1, 11'd50, 64'd5000, 1'b0, 11'd0, 1'b0);

    // Debounce: 100,101,100 publishes 100; drift to 101 follows; 140 restarts count.
    peak_frame("deb1", 11'd100, 64'd7000, 1'b0, 11'd0, 1'b0);
    peak_frame("deb2", 11'd101, 64'd7000, 1'b0, 11'd0, 1'b0);
    peak_frame("deb3", 11'd100, 64'd7000, 1'b1, 11'd100, 1'b1);
    peak_frame("drift", 11'd101, 64'd7000, 1'b1, 11'd101, 1'b1);
    peak_frame("jump", 11'd140, 64'd7000, 1'b1, 11'd101, 1'b0);

    // Three frames with nothing above THRESH drop the note.
    quiet_frame("quiet1", 1'b1, 11'd101, 1'b0);
    quiet_frame("quiet2", 1'b1, 11'd101, 1'b0);
    quiet_frame("quiet3", 1'b0, 11'd101, 1'b1);

    // IDLE ignores done and mag_valid.
    send_bin(11'd300, 64'd99999, 1'b1);
    chk("idle/peak_valid", 64'(peak_valid), 64'd0);
    tick();
    chk("idle/peak_index", 64'(peak_index), 64'd0);

    // Start during SCAN aborts the frame; the earlier bin 30 must not survive.
    send_start();
    send_bin(11'd30, 64'd8000, 1'b0);
    send_start();
    chk("abort/frame_err", 64'(frame_err), 64'd1);
    chk("abort/peak_valid", 64'(peak_valid), 64'd0);
    send_bin(11'd70, 64'd6000, 1'b1);
    chk("abort/frame_err_low", 64'(frame_err), 64'd0);
    end_frame("abort", 1'b1, 11'd70, 64'd6000, 1'b0, 11'd101, 1'b0);

    // Asynchronous reset in the middle of SCAN.
    send_start();
    send_bin(11'd80, 64'd9000, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_scan");
    tick();
    reset_n = 1'b1;
    tick();
    peak_frame("post_rst1", 11'd90, 64'd7000, 1'b0, 11'd0, 1'b0);

    // Asynchronous reset during UPDATE.
    send_start();
    send_bin(11'd95, 64'd6000, 1'b1);
    chk("rst_upd/peak_index_pre", 64'(peak_index), 64'd95);
    tick();
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_upd");
    tick();
    reset_n = 1'b1;
    tick();

    // Range boundaries: MIN_BIN and MAX_BIN are both candidates.
    send_start();
    send_bin(11'd2, 64'd5000, 1'b0);
    send_bin(11'd1023, 64'd6000, 1'b1);
    end_frame("bounds", 1'b1, 11'd1023, 64'd6000, 1'b0, 11'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
